hazard_ctrl_unit: RTL and testbench

//  Generates the IF/ID register controls: IFIDWrite (hold) and IF_flush (bubble). Also drives PCWrite, IDEX_flush and EXMEM_hold.

---
 rtl/hazard_ctrl_unit_pkg.sv | 21 ++
 rtl/hazard_ctrl_unit_if.sv | 42 ++++
 rtl/hazard_ctrl_unit_sat_counter.sv | 32 +++
 rtl/hazard_ctrl_unit.sv | 115 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline types for the hazard control unit.
// Holds the FSM encoding, register address width and the control bundle.
package hazard_ctrl_unit_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic if_flush;
        logic idex_flush;
        logic exmem_hold;
    } hz_ctl_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle of the hazard control unit.
// master = pipeline datapath, slave = hazard unit.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    import hazard_ctrl_unit_pkg::*;

    logic                  IDEX_MemRead;
    logic [REG_ADDR_W-1:0] IDEX_rd;
    logic [REG_ADDR_W-1:0] IFID_rs1;
    logic [REG_ADDR_W-1:0] IFID_rs2;
    logic                  IFID_use_rs1;
    logic                  IFID_use_rs2;
    logic                  EX_redirect;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IF_flush;
    logic                  IDEX_flush;
    logic                  EXMEM_hold;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2,
        output IFID_use_rs1, IFID_use_rs2, EX_redirect,
        output dmem_req, dmem_ready,
        input  PCWrite, IFIDWrite, IF_flush, IDEX_flush,
        input  EXMEM_hold, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2,
        input  IFID_use_rs1, IFID_use_rs2, EX_redirect,
        input  dmem_req, dmem_ready,
        output PCWrite, IFIDWrite, IF_flush, IDEX_flush,
        output EXMEM_hold, mem_timeout, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// IF/ID hazard control: load-use stalls, EX redirects, data-memory waits.
// Mealy outputs from current state and inputs; saturating perf counters.
module hazard_ctrl_unit #(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 16
) (
    input logic clk,
    input logic reset,
    hazard_ctrl_unit_if.slave hz
);
    import hazard_ctrl_unit_pkg::*;

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e   state_q, state_d;
    logic [2:0]  redir_q, redir_d;
    logic [TO_W-1:0] to_q, to_d;
    logic        tmo_q, tmo_d;
    logic        lu;
    logic        memwait;
    hz_ctl_t     ctl;

    always_comb begin
        lu = hz.IDEX_MemRead && (hz.IDEX_rd != '0) &&
             ((hz.IFID_use_rs1 && (hz.IFID_rs1 == hz.IDEX_rd)) ||
              (hz.IFID_use_rs2 && (hz.IFID_rs2 == hz.IDEX_rd)));
        // A wait raised during REDIRECT also freezes; redir_q survives it.
        memwait = (state_q == MEM_WAIT) ||
                  (hz.dmem_req && !hz.dmem_ready);
    end

    always_comb begin
        state_d = state_q;
        redir_d = redir_q;
        to_d    = to_q;
        tmo_d   = tmo_q;
        ctl     = '{pc_write: 1'b1, ifid_write: 1'b1,
                    if_flush: 1'b0, idex_flush: 1'b0,
                    exmem_hold: 1'b0};
        if (reset) begin
            ctl = '{pc_write: 1'b0, ifid_write: 1'b0,
                    if_flush: 1'b1, idex_flush: 1'b1,
                    exmem_hold: 1'b0};
        end else if (memwait) begin
            ctl = '{pc_write: 1'b0, ifid_write: 1'b0,
                    if_flush: 1'b0, idex_flush: 1'b0,
                    exmem_hold: 1'b1};
            if (state_q != MEM_WAIT) begin
                state_d = MEM_WAIT;
                to_d    = TO_W'(1);
            end else if (hz.dmem_ready) begin
                state_d = (redir_q != '0) ? REDIRECT : RUN;
            end else if (to_q != TO_W'(MEM_TIMEOUT)) begin
                to_d = to_q + 1'b1;
            end
            if (to_d == TO_W'(MEM_TIMEOUT)) begin
                tmo_d = 1'b1;
            end
        end else if (hz.EX_redirect) begin
            ctl.if_flush   = 1'b1;
            ctl.idex_flush = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
                state_d = REDIRECT;
                redir_d = 3'(REDIRECT_CYCLES - 1);
            end
        end else if (state_q == REDIRECT) begin
            ctl.if_flush = 1'b1;
            redir_d      = redir_q - 1'b1;
            if (redir_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (lu) begin
            ctl.pc_write   = 1'b0;
            ctl.ifid_write = 1'b0;
            ctl.idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            redir_q <= '0;
            to_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
            to_q    <= to_d;
            tmo_q   <= tmo_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (!ctl.pc_write),
        .count_o (hz.stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (ctl.if_flush),
        .count_o (hz.flush_count)
    );

    assign hz.PCWrite     = ctl.pc_write;
    assign hz.IFIDWrite   = ctl.ifid_write;
    assign hz.IF_flush    = ctl.if_flush;
    assign hz.IDEX_flush  = ctl.idex_flush;
    assign hz.EXMEM_hold  = ctl.exmem_hold;
    assign hz.mem_timeout = tmo_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (REDIRECT_CYCLES=2, MEM_TIMEOUT=4, CNT_W=3).
// Control vector order: {PCWrite, IFIDWrite, IF_flush, IDEX_flush, EXMEM_hold}.
module tb_hazard_ctrl_unit;

    localparam logic [4:0] C_RUN  = 5'b11000;
    localparam logic [4:0] C_RST  = 5'b00110;
    localparam logic [4:0] C_MEM  = 5'b00001;
    localparam logic [4:0] C_RED1 = 5'b11110;
    localparam logic [4:0] C_RED2 = 5'b11100;
    localparam logic [4:0] C_LU   = 5'b00010;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    hazard_ctrl_unit_if #(.CNT_W(3)) hz ();

    hazard_ctrl_unit #(
        .REDIRECT_CYCLES (2),
        .MEM_TIMEOUT     (4),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4:0] ctl = {hz.PCWrite, hz.IFIDWrite, hz.IF_flush,
                      hz.IDEX_flush, hz.EXMEM_hold};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.IDEX_MemRead = 1'b0;
        hz.IDEX_rd      = '0;
        hz.IFID_rs1     = '0;
        hz.IFID_rs2     = '0;
        hz.IFID_use_rs1 = 1'b0;
        hz.IFID_use_rs2 = 1'b0;
        hz.EX_redirect  = 1'b0;
        hz.dmem_req     = 1'b0;
        hz.dmem_ready   = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        hz.IDEX_MemRead = 1'b1;
        hz.IDEX_rd      = r;
        hz.IFID_rs1     = r;
        hz.IFID_use_rs1 = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b1;
        #2;
        chk("rst_ctl", ctl, C_RST);
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("post_rst_ctl", ctl, C_RUN);
        chk("post_rst_stall", hz.stall_count, 0);
        chk("post_rst_flush", hz.flush_count, 0);
        chk("post_rst_tmo", hz.mem_timeout, 0);
        tick();

        hz.IDEX_MemRead = 1'b1;
        hz.IDEX_rd      = 5'd5;
        hz.IFID_rs1     = 5'd1;
        hz.IFID_rs2     = 5'd5;
        hz.IFID_use_rs1 = 1'b1;
        hz.IFID_use_rs2 = 1'b1;
        #2;
        chk("lu_rs2_ctl", ctl, C_LU);
        tick();
        idle();
        #2;
        chk("lu_after_ctl", ctl, C_RUN);
        chk("lu_stall_cnt", hz.stall_count, 1);
        tick();

        hz.IDEX_MemRead = 1'b1;
        hz.IDEX_rd      = 5'd0;
        hz.IFID_use_rs1 = 1'b1;
        hz.IFID_use_rs2 = 1'b1;
        #2;
        chk("lu_x0_ctl", ctl, C_RUN);
        tick();
        hz.IDEX_rd      = 5'd5;
        hz.IFID_rs1     = 5'd5;
        hz.IFID_rs2     = 5'd3;
        hz.IFID_use_rs1 = 1'b0;
        hz.IFID_use_rs2 = 1'b0;
        #2;
        chk("lu_nouse_ctl", ctl, C_RUN);
        tick();
        idle();
        #2;
        chk("nolu_stall_cnt", hz.stall_count, 1);
        chk("nolu_flush_cnt", hz.flush_count, 0);

        hz.EX_redirect = 1'b1;
        #2;
        chk("redir1_ctl", ctl, C_RED1);
        tick();
        hz.EX_redirect = 1'b0;
        #2;
        chk("redir2_ctl", ctl, C_RED2);
        tick();
        #2;
        chk("redir_done_ctl", ctl, C_RUN);
        chk("redir_flush_cnt", hz.flush_count, 2);

        hz.dmem_req = 1'b1;
        #2;
        chk("mw1_ctl", ctl, C_MEM);
        tick();
        hz.EX_redirect = 1'b1;
        set_lu(5'd9);
        #2;
        chk("mw2_ctl", ctl, C_MEM);
        tick();
        #2;
        chk("mw3_ctl", ctl, C_MEM);
        tick();
        hz.dmem_ready = 1'b1;
        #2;
        chk("mw4_ctl", ctl, C_MEM);
        tick();
        idle();
        #2;
        chk("mw_done_ctl", ctl, C_RUN);
        chk("mw_stall_cnt", hz.stall_count, 5);
        chk("mw_flush_cnt", hz.flush_count, 2);
        chk("mw_no_tmo", hz.mem_timeout, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("rst2_stall", hz.stall_count, 0);
        chk("rst2_flush", hz.flush_count, 0);

        hz.dmem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 3) chk("tmo_wait3", hz.mem_timeout, 0);
            if (i == 4) chk("tmo_wait4", hz.mem_timeout, 1);
        end
        hz.dmem_ready = 1'b1;
        #2;
        chk("tmo_ready_ctl", ctl, C_MEM);
        tick();
        idle();
        #2;
        chk("tmo_run_ctl", ctl, C_RUN);
        chk("tmo_sticky", hz.mem_timeout, 1);
        chk("tmo_stall_sat", hz.stall_count, 7);
        tick();
        #2;
        chk("tmo_sticky2", hz.mem_timeout, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("tmo_cleared", hz.mem_timeout, 0);

        set_lu(5'd7);
        #2;
        chk("sat_lu_ctl", ctl, C_LU);
        for (int i = 0; i < 10; i++) tick();
        idle();
        #2;
        chk("sat_stall_cnt", hz.stall_count, 7);
        tick();

        hz.EX_redirect = 1'b1;
        tick();
        hz.EX_redirect = 1'b0;
        hz.dmem_req    = 1'b1;
        #2;
        chk("rmw1_ctl", ctl, C_MEM);
        tick();
        hz.dmem_ready = 1'b1;
        #2;
        chk("rmw2_ctl", ctl, C_MEM);
        tick();
        idle();
        #2;
        chk("rmw_resume_ctl", ctl, C_RED2);
        tick();
        #2;
        chk("rmw_done_ctl", ctl, C_RUN);

        hz.EX_redirect = 1'b1;
        tick();
        hz.EX_redirect = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_redir_ctl", ctl, C_RST);
        tick();
        reset = 1'b0;
        #2;
        chk("rst_redir_run", ctl, C_RUN);
        chk("rst_redir_flush", hz.flush_count, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
